// File: rtl/safelock_pkg.sv
// Shared safelock display definitions: active-high 7-segment glyphs ({g,f,e,d,c,b,a}),
// the blink phase type and a counter-width helper.
package safelock_pkg;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        PHASE_VISIBLE = 1'b0,
        PHASE_HIDDEN  = 1'b1
    } blinkPhase_e;

    // Width of a counter holding 0..n-1, never narrower than one bit.
    function automatic int cntWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational nibble-to-glyph decoder; a masked digit renders as a lone dash.
// Output is active-high, polarity is applied by the caller.
module seg7_encoder
    import safelock_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       mask_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (mask_i) begin
            seg_o = SEG_DASH;
        end else begin
            case (nibble_i)
                4'h0: seg_o = SEG_0;
                4'h1: seg_o = SEG_1;
                4'h2: seg_o = SEG_2;
                4'h3: seg_o = SEG_3;
                4'h4: seg_o = SEG_4;
                4'h5: seg_o = SEG_5;
                4'h6: seg_o = SEG_6;
                4'h7: seg_o = SEG_7;
                4'h8: seg_o = SEG_8;
                4'h9: seg_o = SEG_9;
                4'hA: seg_o = SEG_A;
                4'hB: seg_o = SEG_B;
                4'hC: seg_o = SEG_C;
                4'hD: seg_o = SEG_D;
                4'hE: seg_o = SEG_E;
                4'hF: seg_o = SEG_F;
            endcase
        end
    end

endmodule

// File: rtl/password_display_scanner.sv
// Time-multiplexed 7-segment scanner for the safelock password display with per-digit
// masking, anti-ghosting guard cycles and whole-display blink.
module password_display_scanner
    import safelock_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int GUARD        = 1,
    parameter int BLINK_FRAMES = 64,
    parameter bit SEG_ACT_LOW  = 1'b1,
    parameter bit AN_ACT_LOW   = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_en,
    input  logic                    i_load,
    input  logic [4*NUM_DIGITS-1:0] i_password,
    input  logic [NUM_DIGITS-1:0]   i_mask,
    input  logic                    i_blink,
    output logic [6:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_an,
    output logic                    o_frame_done
);

    localparam int SLOT_W = cntWidth(SCAN_DIV);
    localparam int IDX_W  = cntWidth(NUM_DIGITS);
    localparam int FRM_W  = cntWidth(BLINK_FRAMES);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [SLOT_W-1:0] GUARD_CYC = SLOT_W'(GUARD);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [FRM_W-1:0]  FRM_LAST  = FRM_W'(BLINK_FRAMES - 1);

    localparam logic [6:0]            SEG_OFF = SEG_ACT_LOW ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACT_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
    logic [NUM_DIGITS-1:0]   mask_q, mask_d;
    logic [SLOT_W-1:0]       slotCnt_q, slotCnt_d;
    logic [IDX_W-1:0]        digitIdx_q, digitIdx_d;
    logic [FRM_W-1:0]        frameCnt_q, frameCnt_d;
    blinkPhase_e             phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    frameDone_q, frameDone_d;

    logic [3:0]            curNibble;
    logic                  curMask;
    logic [NUM_DIGITS-1:0] anSel;
    logic [6:0]            encSeg;
    logic                  lastCycle;

    // The counters point at the slot cycle the next edge will present, so after a
    // disable the very first enabled edge shows digit0 cycle 0.
    always_comb begin
        curNibble = 4'h0;
        curMask   = 1'b0;
        anSel     = AN_OFF;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digitIdx_q == IDX_W'(k)) begin
                curNibble = snap_q[4*k +: 4];
                curMask   = mask_q[k];
                anSel[k]  = ~AN_ACT_LOW;
            end
        end
    end

    seg7_encoder u_encoder (
        .nibble_i (curNibble),
        .mask_i   (curMask),
        .seg_o    (encSeg)
    );

    assign lastCycle = (slotCnt_q == SLOT_LAST) && (digitIdx_q == IDX_LAST);

    always_comb begin
        snap_d      = i_load ? i_password : snap_q;
        mask_d      = i_load ? i_mask : mask_q;
        slotCnt_d   = slotCnt_q;
        digitIdx_d  = digitIdx_q;
        frameCnt_d  = frameCnt_q;
        phase_d     = phase_q;
        seg_d       = seg_q;
        an_d        = an_q;
        frameDone_d = 1'b0;

        if (!i_en) begin
            slotCnt_d  = '0;
            digitIdx_d = '0;
            frameCnt_d = '0;
            phase_d    = PHASE_VISIBLE;
            seg_d      = SEG_OFF;
            an_d       = AN_OFF;
        end else begin
            if (!i_blink) begin
                frameCnt_d = '0;
                phase_d    = PHASE_VISIBLE;
            end else if (lastCycle) begin
                if (frameCnt_q == FRM_LAST) begin
                    frameCnt_d = '0;
                    phase_d    = (phase_q == PHASE_HIDDEN) ? PHASE_VISIBLE : PHASE_HIDDEN;
                end else begin
                    frameCnt_d = frameCnt_q + 1'b1;
                end
            end

            if (slotCnt_q == '0) begin
                seg_d = SEG_ACT_LOW ? ~encSeg : encSeg;
            end

            // Anodes only re-enable at a guard end, so blink changes never light a partial slot.
            if (slotCnt_q < GUARD_CYC) begin
                an_d = AN_OFF;
            end else if (slotCnt_q == GUARD_CYC) begin
                an_d = (phase_d == PHASE_HIDDEN) ? AN_OFF : anSel;
            end

            frameDone_d = lastCycle;

            if (slotCnt_q == SLOT_LAST) begin
                slotCnt_d  = '0;
                digitIdx_d = (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + 1'b1;
            end else begin
                slotCnt_d = slotCnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            snap_q      <= '0;
            mask_q      <= '0;
            slotCnt_q   <= '0;
            digitIdx_q  <= '0;
            frameCnt_q  <= '0;
            phase_q     <= PHASE_VISIBLE;
            seg_q       <= SEG_OFF;
            an_q        <= AN_OFF;
            frameDone_q <= 1'b0;
        end else begin
            snap_q      <= snap_d;
            mask_q      <= mask_d;
            slotCnt_q   <= slotCnt_d;
            digitIdx_q  <= digitIdx_d;
            frameCnt_q  <= frameCnt_d;
            phase_q     <= phase_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            frameDone_q <= frameDone_d;
        end
    end

    assign o_seg        = seg_q;
    assign o_an         = an_q;
    assign o_frame_done = frameDone_q;

endmodule
